phy_rx_lane_align: RTL

Lane alignment controller that sequences the two-lane serial PHY receiver.
- Watches the raw serial streams in_0 and in_1 at the 8x bit clock.
- Finds symbol boundaries by hunting for the COM character on each lane.
- Declares each lane active after a run of boundary-aligned COMs.
- Drives the receiver's enable only when both lanes are locked, and supplies a per-lane symbol-boundary strobe.

---
 rtl/phy_rx_lane_align.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/phy_rx_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : phy_rx_lane_align                                          |
// | Description : Two-lane serial PHY receive alignment controller. Each    |
// |               lane hunts for the COM character in its raw bit stream,   |
// |               confirms LOCK_COUNT boundary-aligned COMs, then tracks    |
// |               symbol boundaries until MAX_GAP consecutive boundary      |
// |               symbols arrive without a COM.                             |
// | Ports       : clk_8f      bit clock, one serial bit per lane per edge   |
// |               reset       asynchronous active-high reset                |
// |               enable      global enable, low holds both lanes in SEARCH |
// |               in_0/in_1   serial data (MSB first) for lane 0/1          |
// |               active_0/1  lane locked                                   |
// |               boundary_0/1 one-cycle pulse on a symbol-completing edge  |
// |                           while locked                                  |
// |               rx_enable   enable & active_0 & active_1                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module phy_rx_lane_align #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         MAX_GAP    = 16
) (
  input  logic clk_8f,
  input  logic reset,
  input  logic enable,
  input  logic in_0,
  input  logic in_1,
  output logic active_0,
  output logic active_1,
  output logic boundary_0,
  output logic boundary_1,
  output logic rx_enable
);

  localparam logic [3:0] c_lock_count = 4'(LOCK_COUNT);
  localparam logic [7:0] c_max_gap    = 8'(MAX_GAP);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lane_state_t;

  logic [1:0] w_in;
  assign w_in = {in_1, in_0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      lane_state_t r_state;
      logic [7:0]  r_sr;
      logic [2:0]  r_bit_cnt;
      logic [3:0]  r_com_cnt;
      logic [7:0]  r_gap_cnt;
      logic        r_active;
      logic        r_boundary;

      logic [7:0]  w_sr_next;
      logic        w_match;
      logic        w_at_boundary;

      // The match includes the bit being sampled on this edge, so a COM is
      // recognised on the very edge that completes it.
      assign w_sr_next     = {r_sr[6:0], w_in[gi]};
      assign w_match       = (w_sr_next == COM);
      assign w_at_boundary = (r_bit_cnt == 3'd7);

      always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
          r_state    <= SEARCH;
          r_sr       <= '0;
          r_bit_cnt  <= '0;
          r_com_cnt  <= '0;
          r_gap_cnt  <= '0;
          r_active   <= 1'b0;
          r_boundary <= 1'b0;
        end else if (!enable) begin
          r_state    <= SEARCH;
          r_sr       <= '0;
          r_bit_cnt  <= '0;
          r_com_cnt  <= '0;
          r_gap_cnt  <= '0;
          r_active   <= 1'b0;
          r_boundary <= 1'b0;
        end else begin
          r_sr       <= w_sr_next;
          r_boundary <= 1'b0;
          case (r_state)
            SEARCH: begin
              r_bit_cnt <= 3'd0;
              if (w_match) begin
                r_state   <= CHECK;
                r_com_cnt <= 4'd1;
              end
            end

            CHECK: begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              // Only boundary edges are judged; a false COM straddling two
              // symbols is ignored.
              if (w_at_boundary) begin
                if (w_match) begin
                  if (r_com_cnt + 4'd1 == c_lock_count) begin
                    r_state    <= LOCKED;
                    r_com_cnt  <= c_lock_count;
                    r_gap_cnt  <= 8'd0;
                    r_active   <= 1'b1;
                    r_boundary <= 1'b1;
                  end else begin
                    r_com_cnt <= r_com_cnt + 4'd1;
                  end
                end else begin
                  // Hunting resumes on the following edge, not this one.
                  r_state   <= SEARCH;
                  r_com_cnt <= 4'd0;
                  r_bit_cnt <= 3'd0;
                end
              end
            end

            LOCKED: begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_at_boundary) begin
                if (w_match) begin
                  r_gap_cnt  <= 8'd0;
                  r_boundary <= 1'b1;
                end else if (r_gap_cnt + 8'd1 == c_max_gap) begin
                  r_state   <= SEARCH;
                  r_active  <= 1'b0;
                  r_bit_cnt <= 3'd0;
                  r_com_cnt <= 4'd0;
                  r_gap_cnt <= 8'd0;
                end else begin
                  r_gap_cnt  <= r_gap_cnt + 8'd1;
                  r_boundary <= 1'b1;
                end
              end
            end

            default: begin
              r_state   <= SEARCH;
              r_bit_cnt <= 3'd0;
              r_com_cnt <= 4'd0;
              r_gap_cnt <= 8'd0;
              r_active  <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

  assign active_0   = g_lane[0].r_active;
  assign active_1   = g_lane[1].r_active;
  assign boundary_0 = g_lane[0].r_boundary;
  assign boundary_1 = g_lane[1].r_boundary;
  assign rx_enable  = enable & active_0 & active_1;

endmodule
`default_nettype wire
